// File: rtl/gemm_tile_dispatcher_if.sv
// Job-descriptor and command/completion handshake bundle for gemm_tile_dispatcher.
// master = dispatcher side, slave = host/CSR plus control_unit side.
interface gemm_tile_dispatcher_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  job_valid;
  logic                  job_ready;
  logic [ADDR_WIDTH-1:0] job_base_a;
  logic [ADDR_WIDTH-1:0] job_base_b;
  logic [ADDR_WIDTH-1:0] job_base_c;
  logic [ADDR_WIDTH-1:0] job_base_d;
  logic [ADDR_WIDTH-1:0] job_stride_a;
  logic [ADDR_WIDTH-1:0] job_stride_b;
  logic [ADDR_WIDTH-1:0] job_stride_c;
  logic [ADDR_WIDTH-1:0] job_stride_d;
  logic [7:0]            job_num_tiles;
  logic [7:0]            job_len_m;
  logic [7:0]            job_len_k;
  logic [7:0]            job_len_n;
  logic                  cmd_valid;
  logic [63:0]           cmd_data;
  logic                  cmd_ready;
  logic                  done_irq;

  modport master (
    input  job_valid, job_base_a, job_base_b, job_base_c, job_base_d,
    input  job_stride_a, job_stride_b, job_stride_c, job_stride_d,
    input  job_num_tiles, job_len_m, job_len_k, job_len_n,
    output job_ready,
    output cmd_valid, cmd_data,
    input  cmd_ready, done_irq
  );

  modport slave (
    output job_valid, job_base_a, job_base_b, job_base_c, job_base_d,
    output job_stride_a, job_stride_b, job_stride_c, job_stride_d,
    output job_num_tiles, job_len_m, job_len_k, job_len_n,
    input  job_ready,
    input  cmd_valid, cmd_data,
    output cmd_ready, done_irq
  );
endinterface

// File: rtl/gemm_tile_dispatcher.sv
// Expands one GEMM job descriptor into num_tiles 64-bit tile commands and tracks completions.
// Optional watchdog enabled by defining DISPATCH_WATCHDOG_EN.
module gemm_tile_dispatcher #(
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned WDT_CYCLES      = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  gemm_tile_dispatcher_if.master        bus,
  output logic                          busy,
  output logic                          job_done,
  output logic [3:0]                    outstanding,
  output logic                          err_spurious,
  output logic                          err_timeout
);

  localparam int unsigned AW     = ADDR_WIDTH;
  localparam int unsigned SLOT_W = 10;

  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 10) begin : g_bad_addr_width
    $error("gemm_tile_dispatcher: ADDR_WIDTH must be 1..10");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_max_outstanding
    $error("gemm_tile_dispatcher: MAX_OUTSTANDING must be 1..15");
  end
  if (WDT_CYCLES < 1 || WDT_CYCLES > 65535) begin : g_bad_wdt_cycles
    $error("gemm_tile_dispatcher: WDT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state;
  logic          job_ready_q;
  logic [AW-1:0] addr_a, addr_b, addr_c, addr_d;
  logic [AW-1:0] stride_a, stride_b, stride_c, stride_d;
  logic [7:0]    len_m, len_k, len_n;
  logic [7:0]    num_tiles, tile_idx, tiles_done;

  logic          job_acc, cmd_acc, irq_ok, irq_spur;
  logic [3:0]    outstanding_nx;
  logic [7:0]    tiles_done_nx;

  // Handshake decode and next-state completion counts
  always_comb begin
    job_acc        = (state == IDLE) && bus.job_valid && job_ready_q;
    cmd_acc        = bus.cmd_valid && bus.cmd_ready;
    irq_ok         = bus.done_irq && (outstanding != 4'd0);
    irq_spur       = bus.done_irq && (outstanding == 4'd0);
    outstanding_nx = outstanding + 4'(cmd_acc) - 4'(irq_ok);
    tiles_done_nx  = job_acc ? 8'd0 : tiles_done + 8'(irq_ok);
  end

  // cmd_valid never looks at cmd_ready, only at registered state
  assign bus.cmd_valid = (state == ISSUE) && (outstanding < 4'(MAX_OUTSTANDING));
  assign bus.cmd_data  = {SLOT_W'(addr_d), SLOT_W'(addr_c), SLOT_W'(addr_b), SLOT_W'(addr_a),
                          len_n, len_k, len_m};
  assign bus.job_ready = job_ready_q;
  assign busy          = (state != IDLE);
  assign job_done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      job_ready_q  <= 1'b0;
      addr_a       <= '0;
      addr_b       <= '0;
      addr_c       <= '0;
      addr_d       <= '0;
      stride_a     <= '0;
      stride_b     <= '0;
      stride_c     <= '0;
      stride_d     <= '0;
      len_m        <= 8'd0;
      len_k        <= 8'd0;
      len_n        <= 8'd0;
      num_tiles    <= 8'd0;
      tile_idx     <= 8'd0;
      tiles_done   <= 8'd0;
      outstanding  <= 4'd0;
      err_spurious <= 1'b0;
    end else begin
      outstanding <= outstanding_nx;
      tiles_done  <= tiles_done_nx;
      if (irq_spur)     err_spurious <= 1'b1;
      else if (job_acc) err_spurious <= 1'b0;

      case (state)
        IDLE: begin
          job_ready_q <= 1'b1;
          if (job_acc) begin
            job_ready_q <= 1'b0;
            addr_a      <= bus.job_base_a;
            addr_b      <= bus.job_base_b;
            addr_c      <= bus.job_base_c;
            addr_d      <= bus.job_base_d;
            stride_a    <= bus.job_stride_a;
            stride_b    <= bus.job_stride_b;
            stride_c    <= bus.job_stride_c;
            stride_d    <= bus.job_stride_d;
            len_m       <= bus.job_len_m;
            len_k       <= bus.job_len_k;
            len_n       <= bus.job_len_n;
            num_tiles   <= bus.job_num_tiles;
            tile_idx    <= 8'd0;
            state       <= (bus.job_num_tiles == 8'd0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_acc) begin
            addr_a   <= addr_a + stride_a;
            addr_b   <= addr_b + stride_b;
            addr_c   <= addr_c + stride_c;
            addr_d   <= addr_d + stride_d;
            tile_idx <= tile_idx + 8'd1;
            if (tile_idx == num_tiles - 8'd1)
              state <= (tiles_done_nx == num_tiles) ? DONE : DRAIN;
          end
        end
        DRAIN: begin
          if (tiles_done_nx == num_tiles) state <= DONE;
        end
        DONE: begin
          state       <= IDLE;
          job_ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISPATCH_WATCHDOG_EN
  logic [15:0] wdt_cnt;

  // Counts cycles with work in flight and no completion; flag is sticky until next job
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt     <= 16'd0;
      err_timeout <= 1'b0;
    end else if (job_acc || bus.done_irq || (outstanding == 4'd0)) begin
      wdt_cnt <= 16'd0;
      if (job_acc) err_timeout <= 1'b0;
    end else begin
      if (wdt_cnt != 16'hFFFF) wdt_cnt <= wdt_cnt + 16'd1;
      if (wdt_cnt + 16'd1 == 16'(WDT_CYCLES)) err_timeout <= 1'b1;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gemm_tile_dispatcher.sv
// Directed self-checking bench for gemm_tile_dispatcher (MAX_OUTSTANDING=4, WDT_CYCLES=64).
module tb_gemm_tile_dispatcher;
  localparam int unsigned AW = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy, job_done, err_spurious, err_timeout;
  logic [3:0] outstanding;

  always #5 clk = ~clk;

  gemm_tile_dispatcher_if #(.ADDR_WIDTH(AW)) bus ();

  gemm_tile_dispatcher #(.ADDR_WIDTH(AW), .MAX_OUTSTANDING(4), .WDT_CYCLES(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .job_done     (job_done),
    .outstanding  (outstanding),
    .err_spurious (err_spurious),
    .err_timeout  (err_timeout)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_done = 0;
  int          irq_due[$];
  int          acc_cyc[$];
  logic [63:0] acc_log[$];
  bit          auto_irq = 1'b0;
  bit          rand_ready = 1'b0;
  int          irq_delay = 40;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_cmd(input logic [7:0] m, k, n, input logic [9:0] a, b, c, d);
    return {d, c, b, a, n, k, m};
  endfunction

  // One clock: log accepts, advance, then drive scheduled completions / random ready
  task automatic step();
    logic        acc, pend;
    logic [63:0] d_before;
    acc = bus.cmd_valid && bus.cmd_ready;
    if (acc) begin
      acc_log.push_back(bus.cmd_data);
      acc_cyc.push_back(cyc);
      if (auto_irq) irq_due.push_back(cyc + irq_delay);
    end
    pend     = bus.cmd_valid && !acc && !rst;
    d_before = bus.cmd_data;
    @(posedge clk);
    #1;
    cyc++;
    if (job_done) n_done++;
    if (rand_ready) begin
      if (pend && bus.cmd_valid) check("hold_data", bus.cmd_data, d_before);
      bus.cmd_ready = 1'($urandom_range(0, 1));
    end
    bus.done_irq = 1'b0;
    if (irq_due.size() > 0 && irq_due[0] <= cyc) begin
      void'(irq_due.pop_front());
      bus.done_irq = 1'b1;
    end
  endtask

  task automatic clear_log();
    acc_log.delete();
    acc_cyc.delete();
    irq_due.delete();
  endtask

  task automatic start_job(input logic [9:0] ba, bb, bc, bd, sa, sb, sc, sd,
                           input logic [7:0] nt, lm, lk, ln);
    bus.job_base_a   = ba;  bus.job_base_b   = bb;  bus.job_base_c   = bc;  bus.job_base_d   = bd;
    bus.job_stride_a = sa;  bus.job_stride_b = sb;  bus.job_stride_c = sc;  bus.job_stride_d = sd;
    bus.job_num_tiles = nt; bus.job_len_m = lm; bus.job_len_k = lk; bus.job_len_n = ln;
    bus.job_valid = 1'b1;
    for (int i = 0; i < 20 && !bus.job_ready; i++) step();
    check("job_ready_pre_accept", 64'(bus.job_ready), 64'd1);
    step();
    bus.job_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int i;
    start = n_done;
    i = 0;
    while (n_done == start && i < budget) begin
      step();
      i++;
    end
    check({tag, "_job_done"}, 64'(n_done - start), 64'd1);
    check({tag, "_ready_in_done"}, 64'(bus.job_ready), 64'd0);
    step();
    check({tag, "_ready_after"}, 64'(bus.job_ready), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] exp_cmd;
    int          done_snap;

    rst = 1'b1;
    bus.job_valid = 1'b0; bus.cmd_ready = 1'b0; bus.done_irq = 1'b0;
    bus.job_base_a = '0; bus.job_base_b = '0; bus.job_base_c = '0; bus.job_base_d = '0;
    bus.job_stride_a = '0; bus.job_stride_b = '0; bus.job_stride_c = '0; bus.job_stride_d = '0;
    bus.job_num_tiles = 8'd0; bus.job_len_m = 8'd0; bus.job_len_k = 8'd0; bus.job_len_n = 8'd0;

    // Reset values
    repeat (3) step();
    check("rst_job_ready", 64'(bus.job_ready), 64'd0);
    check("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    check("rst_cmd_data", bus.cmd_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_job_done", 64'(job_done), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_err_spurious", 64'(err_spurious), 64'd0);
    check("rst_err_timeout", 64'(err_timeout), 64'd0);
    rst = 1'b0;
    step();
    check("post_rst_job_ready", 64'(bus.job_ready), 64'd1);
    clear_log();

    // Basic three-tile job, completions 40 cycles after each accept
    bus.cmd_ready = 1'b1; auto_irq = 1'b1; irq_delay = 40;
    start_job(10'h000, 10'h100, 10'h200, 10'h300, 10'h010, 10'h010, 10'h010, 10'h010,
              8'd3, 8'd16, 8'd16, 8'd16);
    check("basic_first_valid", 64'(bus.cmd_valid), 64'd1);
    check("basic_first_data", bus.cmd_data, mk_cmd(8'h10, 8'h10, 8'h10, 10'h000, 10'h100, 10'h200, 10'h300));
    done_snap = n_done;
    wait_done("basic", 200);
    repeat (10) step();
    check("basic_done_once", 64'(n_done - done_snap), 64'd1);
    check("basic_n_acc", 64'(acc_log.size()), 64'd3);
    if (acc_log.size() == 3) begin
      check("basic_tile0", acc_log[0], mk_cmd(8'h10, 8'h10, 8'h10, 10'h000, 10'h100, 10'h200, 10'h300));
      check("basic_tile1", acc_log[1], mk_cmd(8'h10, 8'h10, 8'h10, 10'h010, 10'h110, 10'h210, 10'h310));
      check("basic_tile2", acc_log[2], mk_cmd(8'h10, 8'h10, 8'h10, 10'h020, 10'h120, 10'h220, 10'h320));
      check("basic_low24", 64'(acc_log[2][23:0]), 64'h101010);
      check("basic_consecutive", 64'(acc_cyc[2] - acc_cyc[0]), 64'd2);
    end
    clear_log();

    // Throttle: eight tiles, no completions for 100 cycles
    auto_irq = 1'b0; bus.cmd_ready = 1'b1;
    start_job(10'h000, 10'h000, 10'h000, 10'h000, 10'h001, 10'h001, 10'h001, 10'h001,
              8'd8, 8'd1, 8'd1, 8'd1);
    repeat (100) step();
    check("thr_n_acc", 64'(acc_log.size()), 64'd4);
    check("thr_valid_low", 64'(bus.cmd_valid), 64'd0);
    check("thr_outstanding", 64'(outstanding), 64'd4);
`ifdef DISPATCH_WATCHDOG_EN
    check("wdt_err_timeout", 64'(err_timeout), 64'd1);
`else
    check("wdt_err_timeout", 64'(err_timeout), 64'd0);
`endif
    for (int k = 0; k < 4; k++) begin
      irq_due.push_back(cyc);
      repeat (5) step();
      check("thr_release_n_acc", 64'(acc_log.size()), 64'(5 + k));
      check("thr_release_outstanding", 64'(outstanding), 64'd4);
    end
    for (int k = 1; k <= 4; k++) irq_due.push_back(cyc + k);
    wait_done("thr", 50);
    check("thr_total_acc", 64'(acc_log.size()), 64'd8);
    clear_log();

    // Backpressure with random cmd_ready, descending d stride wraps
    auto_irq = 1'b1; irq_delay = 7; rand_ready = 1'b1;
    start_job(10'h005, 10'h011, 10'h022, 10'h033, 10'h001, 10'h002, 10'h003, 10'h3FF,
              8'd6, 8'd1, 8'd2, 8'd3);
    wait_done("bp", 600);
    rand_ready = 1'b0;
    check("bp_n_acc", 64'(acc_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < acc_log.size(); i++) begin
      exp_cmd = mk_cmd(8'd1, 8'd2, 8'd3, 10'(32'h005 + i * 32'h001), 10'(32'h011 + i * 32'h002),
                       10'(32'h022 + i * 32'h003), 10'(32'h033 + i * 32'h3FF));
      check("bp_tile", acc_log[i], exp_cmd);
    end
    clear_log();

    // Address wrap in addr_a
    bus.cmd_ready = 1'b1; irq_delay = 3;
    start_job(10'h3F8, 10'h000, 10'h000, 10'h000, 10'h010, 10'h000, 10'h000, 10'h000,
              8'd2, 8'd0, 8'd0, 8'd0);
    wait_done("wrap", 50);
    check("wrap_n_acc", 64'(acc_log.size()), 64'd2);
    if (acc_log.size() == 2) begin
      check("wrap_a0", 64'(acc_log[0][33:24]), 64'h3F8);
      check("wrap_a1", 64'(acc_log[1][33:24]), 64'h008);
    end
    clear_log();

    // Zero-tile job
    start_job(10'h001, 10'h002, 10'h003, 10'h004, 10'h001, 10'h001, 10'h001, 10'h001,
              8'd0, 8'd1, 8'd1, 8'd1);
    check("zero_job_done", 64'(job_done), 64'd1);
    check("zero_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    step();
    check("zero_job_ready", 64'(bus.job_ready), 64'd1);
    check("zero_job_done_low", 64'(job_done), 64'd0);
    check("zero_n_acc", 64'(acc_log.size()), 64'd0);
    clear_log();

    // Spurious completion in IDLE, cleared by next job accept
    auto_irq = 1'b0;
    irq_due.push_back(cyc);
    step();
    step();
    check("spur_set", 64'(err_spurious), 64'd1);
    check("spur_outstanding", 64'(outstanding), 64'd0);
    auto_irq = 1'b1; irq_delay = 5;
    start_job(10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000,
              8'd1, 8'd2, 8'd2, 8'd2);
    check("spur_cleared", 64'(err_spurious), 64'd0);
    wait_done("spur", 50);
    clear_log();

    // Accept and completion in the same cycle
    auto_irq = 1'b0; bus.cmd_ready = 1'b0;
    start_job(10'h000, 10'h000, 10'h000, 10'h000, 10'h001, 10'h001, 10'h001, 10'h001,
              8'd3, 8'd1, 8'd1, 8'd1);
    bus.cmd_ready = 1'b1;
    step();
    check("sim_out_first", 64'(outstanding), 64'd1);
    bus.done_irq = 1'b1;
    step();
    check("sim_out_same", 64'(outstanding), 64'd1);
    irq_due.push_back(cyc + 2);
    irq_due.push_back(cyc + 3);
    wait_done("sim", 50);
    check("sim_n_acc", 64'(acc_log.size()), 64'd3);
    clear_log();

    // Reset in the middle of ISSUE, then a fresh job
    bus.cmd_ready = 1'b1;
    start_job(10'h100, 10'h101, 10'h102, 10'h103, 10'h004, 10'h004, 10'h004, 10'h004,
              8'd5, 8'd7, 8'd7, 8'd7);
    step();
    step();
    check("mid_n_acc", 64'(acc_log.size()), 64'd2);
    rst = 1'b1; bus.cmd_ready = 1'b0;
    step();
    check("mid_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    check("mid_outstanding", 64'(outstanding), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step();
    clear_log();
    bus.cmd_ready = 1'b1; auto_irq = 1'b1; irq_delay = 6;
    start_job(10'h0AA, 10'h0BB, 10'h0CC, 10'h0DD, 10'h001, 10'h001, 10'h001, 10'h001,
              8'd1, 8'd4, 8'd5, 8'd6);
    check("mid_new_valid", 64'(bus.cmd_valid), 64'd1);
    check("mid_new_data", bus.cmd_data, mk_cmd(8'd4, 8'd5, 8'd6, 10'h0AA, 10'h0BB, 10'h0CC, 10'h0DD));
    wait_done("mid", 50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
